// File: rtl/tenant_demux.sv
// Packet-level 1-to-2 AXI4-Stream demux: whole packets go to output 0 (uid==0) or output 1,
// each output behind a 2-entry skid buffer, with per-output packet counters.
module tenant_demux #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int USER_ID_LSB          = 32,
    parameter int USER_ID_WIDTH        = 8,
    parameter int CNT_WIDTH            = 32
) (
    input  logic                              axis_aclk,
    input  logic                              axis_resetn,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_0_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_0_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_0_tuser,
    output logic                              m_axis_0_tvalid,
    output logic                              m_axis_0_tlast,
    input  logic                              m_axis_0_tready,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_1_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_1_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_1_tuser,
    output logic                              m_axis_1_tvalid,
    output logic                              m_axis_1_tlast,
    input  logic                              m_axis_1_tready,

    output logic [CNT_WIDTH-1:0]              pkt_cnt_0,
    output logic [CNT_WIDTH-1:0]              pkt_cnt_1,
    output logic                              dbg_state
);

    localparam int KEEP_W = C_M_AXIS_DATA_WIDTH / 8;

    typedef enum logic {
        ST_SOP    = 1'b0,
        ST_IN_PKT = 1'b1
    } state_t;

    typedef struct packed {
        logic                            last;
        logic [C_M_AXIS_TUSER_WIDTH-1:0] user;
        logic [KEEP_W-1:0]               keep;
        logic [C_M_AXIS_DATA_WIDTH-1:0]  data;
    } beat_t;

    // Handshake: a beat moves on any interface in a cycle where tvalid and tready
    // are both high at the rising clock edge; a source holds its beat stable until then.

    state_t                state;
    logic                  sel;
    logic                  route_sop;
    logic                  eff_sel;
    logic                  accept;
    beat_t                 in_beat;
    beat_t                 a_q [2];
    beat_t                 b_q [2];
    logic [1:0]            a_vld;
    logic [1:0]            b_vld;
    logic [1:0]            full;
    logic [1:0]            push;
    logic [1:0]            pop;
    logic [1:0]            m_ready;
    logic [CNT_WIDTH-1:0]  cnt [2];

    assign route_sop = (s_axis_tuser[USER_ID_LSB +: USER_ID_WIDTH] != '0);
    assign eff_sel   = (state == ST_SOP) ? route_sop : sel;
    assign m_ready   = {m_axis_1_tready, m_axis_0_tready};

    assign in_beat.last = s_axis_tlast;
    assign in_beat.user = s_axis_tuser;
    assign in_beat.keep = s_axis_tkeep;
    assign in_beat.data = s_axis_tdata;

    // Only the buffer the current beat is steered to can stall the input.
    assign s_axis_tready = ~full[eff_sel];
    assign accept        = s_axis_tvalid & s_axis_tready;

    always_comb begin
        full = '0;
        push = '0;
        pop  = '0;
        for (int n = 0; n < 2; n++) begin
            full[n] = a_vld[n] & b_vld[n];
            pop[n]  = a_vld[n] & m_ready[n];
            push[n] = accept & (eff_sel == 1'(n));
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state <= ST_SOP;
            sel   <= 1'b0;
        end else if (accept) begin
            case (state)
                ST_SOP: begin
                    if (!s_axis_tlast) begin
                        sel   <= route_sop;
                        state <= ST_IN_PKT;
                    end
                end
                ST_IN_PKT: begin
                    if (s_axis_tlast) state <= ST_SOP;
                end
                default: state <= ST_SOP;
            endcase
        end
    end

    // Skid buffers: entry A drives the output, entry B only fills while A is stuck.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            a_vld <= '0;
            b_vld <= '0;
            for (int n = 0; n < 2; n++) begin
                a_q[n] <= '0;
                b_q[n] <= '0;
                cnt[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (pop[n]) begin
                    if (b_vld[n]) begin
                        a_q[n]   <= b_q[n];
                        b_vld[n] <= push[n];
                        if (push[n]) b_q[n] <= in_beat;
                    end else begin
                        a_vld[n] <= push[n];
                        if (push[n]) a_q[n] <= in_beat;
                    end
                end else if (!a_vld[n]) begin
                    a_vld[n] <= push[n];
                    if (push[n]) a_q[n] <= in_beat;
                end else if (push[n]) begin
                    b_q[n]   <= in_beat;
                    b_vld[n] <= 1'b1;
                end
                if (push[n] && s_axis_tlast) cnt[n] <= cnt[n] + 1'b1;
            end
        end
    end

    assign m_axis_0_tvalid = a_vld[0];
    assign m_axis_0_tdata  = a_q[0].data;
    assign m_axis_0_tkeep  = a_q[0].keep;
    assign m_axis_0_tuser  = a_q[0].user;
    assign m_axis_0_tlast  = a_q[0].last;

    assign m_axis_1_tvalid = a_vld[1];
    assign m_axis_1_tdata  = a_q[1].data;
    assign m_axis_1_tkeep  = a_q[1].keep;
    assign m_axis_1_tuser  = a_q[1].user;
    assign m_axis_1_tlast  = a_q[1].last;

    assign pkt_cnt_0 = cnt[0];
    assign pkt_cnt_1 = cnt[1];
    assign dbg_state = state;

endmodule

// File: tb/tb_tenant_demux.sv
// Bench for tenant_demux: each output is modelled as a 2-deep FIFO fed by whole-packet routing.
module tb_tenant_demux;

  localparam int DW = 256;
  localparam int KW = DW / 8;
  localparam int UW = 128;
  localparam int BW = 1 + UW + KW + DW;

  typedef logic [BW-1:0] beat_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic axis_resetn = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic [UW-1:0] s_axis_tuser = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_0_tdata, m_axis_1_tdata;
  logic [KW-1:0] m_axis_0_tkeep, m_axis_1_tkeep;
  logic [UW-1:0] m_axis_0_tuser, m_axis_1_tuser;
  logic          m_axis_0_tvalid, m_axis_1_tvalid;
  logic          m_axis_0_tlast, m_axis_1_tlast;
  logic          m_axis_0_tready = 1'b1;
  logic          m_axis_1_tready = 1'b1;
  logic [31:0]   pkt_cnt_0, pkt_cnt_1;
  logic          dbg_state;

  tenant_demux dut (
    .axis_aclk       (clk),
    .axis_resetn     (axis_resetn),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tkeep    (s_axis_tkeep),
    .s_axis_tuser    (s_axis_tuser),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tready   (s_axis_tready),
    .m_axis_0_tdata  (m_axis_0_tdata),
    .m_axis_0_tkeep  (m_axis_0_tkeep),
    .m_axis_0_tuser  (m_axis_0_tuser),
    .m_axis_0_tvalid (m_axis_0_tvalid),
    .m_axis_0_tlast  (m_axis_0_tlast),
    .m_axis_0_tready (m_axis_0_tready),
    .m_axis_1_tdata  (m_axis_1_tdata),
    .m_axis_1_tkeep  (m_axis_1_tkeep),
    .m_axis_1_tuser  (m_axis_1_tuser),
    .m_axis_1_tvalid (m_axis_1_tvalid),
    .m_axis_1_tlast  (m_axis_1_tlast),
    .m_axis_1_tready (m_axis_1_tready),
    .pkt_cnt_0       (pkt_cnt_0),
    .pkt_cnt_1       (pkt_cnt_1),
    .dbg_state       (dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int total = 0;
  int bad = 0;

  beat_t       exp_q0[$];
  beat_t       exp_q1[$];
  logic [31:0] m_cnt0, m_cnt1;
  logic        m_in_pkt;
  logic        m_dest;

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic model_dest();
    return m_in_pkt ? m_dest : (s_axis_tuser[32 +: 8] != 8'd0);
  endfunction

  function automatic logic model_ready();
    if (model_dest()) return exp_q1.size() < 2;
    return exp_q0.size() < 2;
  endfunction

  always @(posedge clk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      exp_q0.delete();
      exp_q1.delete();
      m_cnt0 = '0;
      m_cnt1 = '0;
      m_in_pkt = 1'b0;
      m_dest = 1'b0;
    end else begin
      logic d, acc;
      d = model_dest();
      acc = s_axis_tvalid && model_ready();
      if (exp_q0.size() > 0 && m_axis_0_tready) void'(exp_q0.pop_front());
      if (exp_q1.size() > 0 && m_axis_1_tready) void'(exp_q1.pop_front());
      if (acc) begin
        if (d) exp_q1.push_back({s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata});
        else   exp_q0.push_back({s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata});
        if (s_axis_tlast) begin
          if (d) m_cnt1 = m_cnt1 + 1;
          else   m_cnt0 = m_cnt0 + 1;
          m_in_pkt = 1'b0;
        end else begin
          m_in_pkt = 1'b1;
          m_dest = d;
        end
      end
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (axis_resetn) begin
      chk("s_tready", s_axis_tready, model_ready());
      chk("m0_valid", m_axis_0_tvalid, exp_q0.size() != 0);
      chk("m1_valid", m_axis_1_tvalid, exp_q1.size() != 0);
      if (exp_q0.size() != 0)
        chk("m0_beat", {m_axis_0_tlast, m_axis_0_tuser, m_axis_0_tkeep, m_axis_0_tdata}, exp_q0[0]);
      if (exp_q1.size() != 0)
        chk("m1_beat", {m_axis_1_tlast, m_axis_1_tuser, m_axis_1_tkeep, m_axis_1_tdata}, exp_q1[0]);
      chk("pkt_cnt_0", pkt_cnt_0, m_cnt0);
      chk("pkt_cnt_1", pkt_cnt_1, m_cnt1);
    end
  end

  // ---------------- driver tasks ----------------
  int   acc_count = 0;
  int   send_waits = 0;
  logic send_done = 1'b0;
  logic abort = 1'b0;
  logic rand_ready = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) begin
        m_axis_0_tready = ($urandom_range(0, 3) != 0);
        m_axis_1_tready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  task automatic do_reset();
    abort = 1'b1;
    s_axis_tvalid = 1'b0;
    axis_resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    axis_resetn = 1'b1;
    abort = 1'b0;
    acc_count = 0;
  endtask

  function automatic logic [UW-1:0] rand_user(input logic [7:0] uid);
    logic [UW-1:0] u;
    u = {$urandom, $urandom, $urandom, $urandom};
    u[32 +: 8] = uid;
    return u;
  endfunction

  // Drives one packet; first-beat uid is uid0, later beats carry uid_rest (or random if rand_rest).
  task automatic send_pkt(input int nb, input logic [7:0] uid0, input logic [7:0] uid_rest,
                          input logic rand_rest, input int idle_max);
    int waits;
    logic rdy;
    send_done = 1'b0;
    send_waits = 0;
    for (int b = 0; b < nb; b++) begin
      int idle;
      idle = (idle_max > 0) ? $urandom_range(0, idle_max) : 0;
      if (idle > 0) begin
        s_axis_tvalid = 1'b0;
        repeat (idle) @(posedge clk);
        #1;
      end
      if (abort) break;
      for (int w = 0; w < DW / 32; w++) s_axis_tdata[w*32 +: 32] = $urandom;
      s_axis_tkeep = $urandom;
      s_axis_tuser = rand_user((b == 0) ? uid0 : (rand_rest ? 8'($urandom) : uid_rest));
      s_axis_tlast = (b == nb - 1);
      s_axis_tvalid = 1'b1;
      waits = 0;
      forever begin
        @(negedge clk);
        rdy = s_axis_tready;
        @(posedge clk);
        #1;
        if (abort) break;
        if (rdy) break;
        waits++;
        if (waits > 200) begin
          total++;
          bad++;
          $display("FAIL accept_timeout beat=%0d actual=stalled required=accept", b);
          break;
        end
      end
      if (abort || waits > 200) break;
      acc_count++;
      send_waits += waits;
    end
    s_axis_tvalid = 1'b0;
    send_done = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ok;
    // Test 1: reset state, then a 4-beat uid=0 packet.
    do_reset();
    @(negedge clk);
    chk("rst_m0_valid", m_axis_0_tvalid, 1'b0);
    chk("rst_m1_valid", m_axis_1_tvalid, 1'b0);
    chk("rst_cnt0", pkt_cnt_0, 32'd0);
    chk("rst_cnt1", pkt_cnt_1, 32'd0);
    @(posedge clk);
    #1;
    send_pkt(4, 8'd0, 8'd0, 1'b0, 0);
    @(negedge clk);
    chk("t1_m0_valid_after_last", m_axis_0_tvalid, 1'b1);
    chk("t1_m0_last", m_axis_0_tlast, 1'b1);
    idle_cycles(3);
    chk("t1_cnt0", pkt_cnt_0, 32'd1);
    chk("t1_cnt1", pkt_cnt_1, 32'd0);

    // Test 2: SOP uid=5, later beats uid=0 stay on output 1.
    do_reset();
    send_pkt(3, 8'd5, 8'd0, 1'b0, 0);
    idle_cycles(3);
    chk("t2_cnt1", pkt_cnt_1, 32'd1);
    chk("t2_cnt0", pkt_cnt_0, 32'd0);

    // Test 3: output 0 stalled, 5-beat packet fills exactly two entries.
    do_reset();
    m_axis_0_tready = 1'b0;
    fork
      send_pkt(5, 8'd0, 8'd0, 1'b0, 0);
    join_none
    repeat (6) @(posedge clk);
    #2;
    chk("t3_accepted", acc_count, 2);
    chk("t3_s_tready", s_axis_tready, 1'b0);
    m_axis_0_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_no_gap", m_axis_0_tvalid, 1'b1);
    end
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(posedge clk);
      if (send_done) ok = 1;
    end
    #1;
    chk("t3_done", ok, 1);
    idle_cycles(2);
    chk("t3_cnt0", pkt_cnt_0, 32'd1);

    // Test 4: output 0 holds 2 beats; a uid=1 single beat still passes on output 1.
    do_reset();
    m_axis_0_tready = 1'b0;
    send_pkt(2, 8'd0, 8'd0, 1'b0, 0);
    send_pkt(1, 8'd1, 8'd0, 1'b0, 0);
    chk("t4_waits", send_waits, 0);
    @(negedge clk);
    chk("t4_m0_stalled_valid", m_axis_0_tvalid, 1'b1);
    chk("t4_cnt1", pkt_cnt_1, 32'd1);
    @(posedge clk);
    #1;
    m_axis_0_tready = 1'b1;
    idle_cycles(4);
    chk("t4_cnt0", pkt_cnt_0, 32'd1);

    // Test 5: alternating single-beat packets, one accept per cycle.
    do_reset();
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      send_pkt(1, (i % 2 == 0) ? 8'd0 : 8'd1, 8'd0, 1'b0, 0);
      ok += send_waits;
    end
    chk("t5_total_waits", ok, 0);
    idle_cycles(2);
    chk("t5_cnt0", pkt_cnt_0, 32'd5);
    chk("t5_cnt1", pkt_cnt_1, 32'd5);

    // Test 6: reset during beat 2 of a 4-beat packet.
    do_reset();
    fork
      send_pkt(4, 8'd0, 8'd0, 1'b0, 0);
    join_none
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (acc_count >= 2) ok = 1;
    end
    chk("t6_reached_beat2", ok, 1);
    #1;
    chk("t6_pre_m0_valid", m_axis_0_tvalid, 1'b1);
    abort = 1'b1;
    axis_resetn = 1'b0;
    #1;
    chk("t6_m0_valid_drop", m_axis_0_tvalid, 1'b0);
    chk("t6_cnt0", pkt_cnt_0, 32'd0);
    chk("t6_cnt1", pkt_cnt_1, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    axis_resetn = 1'b1;
    abort = 1'b0;
    send_pkt(2, 8'd3, 8'd0, 1'b0, 0);
    idle_cycles(3);
    chk("t6_after_cnt1", pkt_cnt_1, 32'd1);
    chk("t6_after_cnt0", pkt_cnt_0, 32'd0);

    // Randomized traffic with random backpressure.
    do_reset();
    rand_ready = 1'b1;
    for (int p = 0; p < 80; p++) begin
      send_pkt($urandom_range(1, 5), ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 255)),
               8'd0, 1'b1, 2);
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    m_axis_0_tready = 1'b1;
    m_axis_1_tready = 1'b1;
    idle_cycles(6);
    chk("rand_drained0", m_axis_0_tvalid, 1'b0);
    chk("rand_drained1", m_axis_1_tvalid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
